// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle RV32 control FSM: FETCH/DECODE/EXEC/MEM/WB with ready handshakes.
// Optional memory-wait timeout is enabled by defining MC_TIMEOUT_EN.
module multicycle_control #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [6:0] i_OPCode,
    input  logic       i_imem_ready,
    input  logic       i_dmem_ready,
    output logic       o_imem_req,
    output logic       o_dmem_req,
    output logic       o_IRWrite,
    output logic       o_PCWrite,
    output logic       o_Branch,
    output logic       o_MemRead,
    output logic       o_MemWrite,
    output logic       o_MemToReg,
    output logic       o_ALUSrc1,
    output logic       o_ALUSrc2,
    output logic [2:0] o_ALUOp,
    output logic       o_RegWrite,
    output logic       o_retire,
    output logic       o_illegal,
    output logic       o_bus_error,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 1..255");
    end

    state_t     state;
    logic [6:0] opcode_q;
    logic       timeout;

    function automatic logic op_supported(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] alu_class(input logic [6:0] op);
        case (op)
            OP_R:             return 3'b010;
            OP_I:             return 3'b011;
            OP_BRANCH:        return 3'b001;
            OP_LUI, OP_AUIPC: return 3'b100;
            default:          return 3'b000;
        endcase
    endfunction

    logic is_load, is_store, is_branch, is_mem, uses_imm;
    assign is_load   = (opcode_q == OP_LOAD);
    assign is_store  = (opcode_q == OP_STORE);
    assign is_branch = (opcode_q == OP_BRANCH);
    assign is_mem    = is_load | is_store;
    assign uses_imm  = is_mem | (opcode_q == OP_I);

`ifdef MC_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIMIT = TIMEOUT_CYCLES[7:0];
    logic [7:0] wait_cnt;
    logic       waiting;

    assign waiting = ((state == S_FETCH) && !i_imem_ready) ||
                     ((state == S_MEM) && !i_dmem_ready);
    assign timeout = waiting && (wait_cnt == TIMEOUT_LIMIT);

    // Cleared whenever not waiting, so every entry into FETCH or MEM starts at zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wait_cnt <= 8'd0;
        end else if (waiting && !timeout) begin
            wait_cnt <= wait_cnt + 8'd1;
        end else begin
            wait_cnt <= 8'd0;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= S_FETCH;
            opcode_q <= 7'd0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (i_imem_ready) begin
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    opcode_q <= i_OPCode;
                    state    <= op_supported(i_OPCode) ? S_EXEC : S_FETCH;
                end
                S_EXEC: begin
                    if (is_branch) begin
                        state <= S_FETCH;
                    end else if (is_mem) begin
                        state <= S_MEM;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (i_dmem_ready) begin
                        state <= is_load ? S_WB : S_FETCH;
                    end else if (timeout) begin
                        state <= S_FETCH;
                    end
                end
                default: state <= S_FETCH;
            endcase
        end
    end

    // Strobes follow the ready inputs within the cycle, and reset forces them low asynchronously.
    always_comb begin
        o_imem_req  = 1'b0;
        o_dmem_req  = 1'b0;
        o_IRWrite   = 1'b0;
        o_PCWrite   = 1'b0;
        o_Branch    = 1'b0;
        o_MemRead   = 1'b0;
        o_MemWrite  = 1'b0;
        o_MemToReg  = 1'b0;
        o_ALUSrc1   = 1'b0;
        o_ALUSrc2   = 1'b0;
        o_ALUOp     = 3'b000;
        o_RegWrite  = 1'b0;
        o_retire    = 1'b0;
        o_illegal   = 1'b0;
        o_bus_error = 1'b0;
        o_state     = state;
        if (!i_rst) begin
            case (state)
                S_FETCH: begin
                    o_imem_req  = !timeout;
                    o_IRWrite   = i_imem_ready;
                    o_PCWrite   = i_imem_ready;
                    o_bus_error = timeout;
                end
                S_DECODE: begin
                    if (!op_supported(i_OPCode)) begin
                        o_illegal = 1'b1;
                        o_retire  = 1'b1;
                    end
                end
                S_EXEC: begin
                    o_ALUOp   = alu_class(opcode_q);
                    o_ALUSrc2 = uses_imm;
                    o_ALUSrc1 = (opcode_q == OP_AUIPC);
                    o_Branch  = is_branch;
                    o_retire  = is_branch;
                end
                S_MEM: begin
                    // A timed-out access drops every request and strobe; only the error flag remains.
                    if (timeout) begin
                        o_bus_error = 1'b1;
                    end else begin
                        o_dmem_req = 1'b1;
                        o_MemRead  = is_load;
                        o_MemWrite = is_store;
                        o_ALUOp    = alu_class(opcode_q);
                        o_ALUSrc2  = uses_imm;
                        o_retire   = i_dmem_ready && is_store;
                    end
                end
                S_WB: begin
                    o_RegWrite = 1'b1;
                    o_MemToReg = is_load;
                    o_retire   = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control against an instruction-level model.
module tb_multicycle_control;

`ifdef MC_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [6:0] i_OPCode = 7'd0;
    logic       i_imem_ready = 1'b0;
    logic       i_dmem_ready = 1'b0;
    logic       o_imem_req, o_dmem_req, o_IRWrite, o_PCWrite, o_Branch, o_MemRead;
    logic       o_MemWrite, o_MemToReg, o_ALUSrc1, o_ALUSrc2, o_RegWrite;
    logic       o_retire, o_illegal, o_bus_error;
    logic [2:0] o_ALUOp, o_state;

    multicycle_control #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_OPCode(i_OPCode),
        .i_imem_ready(i_imem_ready), .i_dmem_ready(i_dmem_ready),
        .o_imem_req(o_imem_req), .o_dmem_req(o_dmem_req),
        .o_IRWrite(o_IRWrite), .o_PCWrite(o_PCWrite), .o_Branch(o_Branch),
        .o_MemRead(o_MemRead), .o_MemWrite(o_MemWrite), .o_MemToReg(o_MemToReg),
        .o_ALUSrc1(o_ALUSrc1), .o_ALUSrc2(o_ALUSrc2), .o_ALUOp(o_ALUOp),
        .o_RegWrite(o_RegWrite), .o_retire(o_retire), .o_illegal(o_illegal),
        .o_bus_error(o_bus_error), .o_state(o_state)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [2:0] state;
        logic imem_req, dmem_req, irw, pcw, br, mr, mw, m2r, s1, s2;
        logic [2:0] aluop;
        logic rw, ret, ill, berr;
    } outs_t;

    typedef struct {
        logic       ir;
        logic       dr;
        logic [6:0] op;
        outs_t      exp;
        string      tag;
    } cyc_t;

    cyc_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Instruction classes: 0 illegal, 1 R, 2 I, 3 LOAD, 4 STORE, 5 BRANCH, 6 LUI, 7 AUIPC
    logic [2:0] alu_tab [8] = '{3'b000, 3'b010, 3'b011, 3'b000, 3'b000, 3'b001, 3'b100, 3'b100};

    function automatic int cls(input logic [6:0] op);
        case (op)
            7'b0110011: return 1;
            7'b0010011: return 2;
            7'b0000011: return 3;
            7'b0100011: return 4;
            7'b1100011: return 5;
            7'b0110111: return 6;
            7'b0010111: return 7;
            default:    return 0;
        endcase
    endfunction

    function automatic outs_t actual();
        return {o_state, o_imem_req, o_dmem_req, o_IRWrite, o_PCWrite, o_Branch,
                o_MemRead, o_MemWrite, o_MemToReg, o_ALUSrc1, o_ALUSrc2, o_ALUOp,
                o_RegWrite, o_retire, o_illegal, o_bus_error};
    endfunction

    task automatic push(input logic ir, input logic dr, input logic [6:0] op,
                        input outs_t e, input string tag);
        cyc_t c;
        c.ir = ir; c.dr = dr; c.op = op; c.exp = e; c.tag = tag;
        q.push_back(c);
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [6:0] rop();
        return 7'($urandom);
    endfunction

    // Expected per-cycle behaviour of one whole instruction; returns its cycle count.
    task automatic add_instr(input logic [6:0] op, input int fwait, input int mwait,
                             input string tag, output int ncyc);
        outs_t e;
        int    c;
        ncyc = 0;
        c = cls(op);
        for (int k = 0; k < fwait; k++) begin
            e = '0; e.imem_req = 1'b1;
            push(1'b0, rb(), rop(), e, {tag, ".fwait"}); ncyc++;
        end
        e = '0; e.imem_req = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
        push(1'b1, rb(), rop(), e, {tag, ".fetch"}); ncyc++;
        e = '0; e.state = 3'd1;
        if (c == 0) begin
            e.ill = 1'b1; e.ret = 1'b1;
        end
        push(rb(), rb(), op, e, {tag, ".decode"}); ncyc++;
        if (c == 0) return;
        e = '0; e.state = 3'd2; e.aluop = alu_tab[c];
        e.s2 = (c == 2 || c == 3 || c == 4);
        e.s1 = (c == 7);
        if (c == 5) begin
            e.br = 1'b1; e.ret = 1'b1;
        end
        push(rb(), rb(), rop(), e, {tag, ".exec"}); ncyc++;
        if (c == 5) return;
        if (c == 3 || c == 4) begin
            for (int k = 0; k <= mwait; k++) begin
                e = '0; e.state = 3'd3; e.dmem_req = 1'b1; e.s2 = 1'b1; e.aluop = 3'b000;
                e.mr = (c == 3); e.mw = (c == 4);
                e.ret = (c == 4) && (k == mwait);
                push(rb(), (k == mwait), rop(), e, {tag, ".mem"}); ncyc++;
            end
            if (c == 4) return;
        end
        e = '0; e.state = 3'd4; e.rw = 1'b1; e.ret = 1'b1; e.m2r = (c == 3);
        push(rb(), rb(), rop(), e, {tag, ".wb"}); ncyc++;
    endtask

`ifdef MC_TIMEOUT_EN
    task automatic add_fetch_timeout(input string tag, output int ncyc);
        outs_t e;
        ncyc = 0;
        for (int k = 0; k < TO; k++) begin
            e = '0; e.imem_req = 1'b1;
            push(1'b0, rb(), rop(), e, {tag, ".wait"}); ncyc++;
        end
        e = '0; e.berr = 1'b1;
        push(1'b0, rb(), rop(), e, {tag, ".err"}); ncyc++;
    endtask

    task automatic add_load_mem_timeout(input string tag);
        outs_t e;
        e = '0; e.imem_req = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
        push(1'b1, rb(), rop(), e, {tag, ".fetch"});
        e = '0; e.state = 3'd1;
        push(rb(), rb(), 7'b0000011, e, {tag, ".decode"});
        e = '0; e.state = 3'd2; e.s2 = 1'b1;
        push(rb(), rb(), rop(), e, {tag, ".exec"});
        for (int k = 0; k < TO; k++) begin
            e = '0; e.state = 3'd3; e.dmem_req = 1'b1; e.mr = 1'b1; e.s2 = 1'b1;
            push(rb(), 1'b0, rop(), e, {tag, ".mwait"});
        end
        e = '0; e.state = 3'd3; e.berr = 1'b1;
        push(rb(), 1'b0, rop(), e, {tag, ".err"});
    endtask
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Single compare process: applies each queued cycle and checks every output bit.
    task automatic run_queue();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            i_imem_ready = c.ir;
            i_dmem_ready = c.dr;
            i_OPCode     = c.op;
            @(negedge i_clk);
            check(c.tag, 32'(actual()), 32'(c.exp));
            @(posedge i_clk);
            #1;
        end
    endtask

    initial begin
        int n;
        outs_t a;
        #2;
        check("reset_outputs_low", 32'(actual()), 32'd0);
        @(posedge i_clk);
        #2;
        check("reset_outputs_low_after_edge", 32'(actual()), 32'd0);
        i_rst = 1'b0;
        #1;
        check("first_cycle_fetch_req", {29'd0, o_state}, 32'd0);
        check("first_cycle_imem_req", {31'd0, o_imem_req}, 32'd1);

        add_instr(7'b0110011, 0, 0, "rtype", n);    check("len_rtype", n, 4);
        add_instr(7'b0000011, 0, 3, "load_w3", n);  check("len_load_w3", n, 8);
        add_instr(7'b0100011, 0, 0, "store", n);    check("len_store", n, 4);
        add_instr(7'b1100011, 0, 0, "branch", n);   check("len_branch", n, 3);
        add_instr(7'b1111111, 0, 0, "illegal7f", n); check("len_illegal", n, 2);
        add_instr(7'b0010011, 2, 0, "itype_fw2", n); check("len_itype_fw2", n, 6);
        add_instr(7'b0110111, 0, 0, "lui", n);
        add_instr(7'b0010111, 0, 0, "auipc", n);
        add_instr(7'b0000011, 1, 0, "load_fw1", n);  check("len_load_fw1", n, 6);
        add_instr(7'b0100011, 0, 2, "store_w2", n);
        add_instr(7'b0000000, 0, 0, "illegal00", n);
`ifdef MC_TIMEOUT_EN
        add_fetch_timeout("fetch_to", n);           check("len_fetch_timeout", n, TO + 1);
        add_instr(7'b0110011, TO, 0, "ready_at_limit", n);
        add_load_mem_timeout("mem_to");
        add_instr(7'b0100011, 0, TO, "mem_ready_at_limit", n);
`else
        add_instr(7'b0110011, 300, 0, "long_fetch_wait", n);
        add_instr(7'b0000011, 0, 260, "long_mem_wait", n);
`endif
        add_instr(7'b0110011, 0, 0, "rtype_tail", n);
        run_queue();

        // Reset raised in the middle of a LOAD's MEM phase.
        i_imem_ready = 1'b1;
        @(posedge i_clk); #1;
        i_imem_ready = 1'b0; i_OPCode = 7'b0000011;
        @(posedge i_clk); #1;
        i_OPCode = 7'd0;
        @(posedge i_clk); #1;
        i_dmem_ready = 1'b0;
        @(negedge i_clk);
        check("mid_reset_in_mem", {29'd0, o_state}, 32'd3);
        #2;
        i_rst = 1'b1;
        #1;
        check("mid_reset_outputs_low", 32'(actual()), 32'd0);
        @(posedge i_clk); #1;
        a = actual();
        check("mid_reset_held_low", 32'(a), 32'd0);
        @(negedge i_clk);
        i_imem_ready = 1'b0;
        i_rst = 1'b0;
        #1;
        a = actual();
        check("post_reset_fetch", {29'd0, a.state}, 32'd0);
        check("post_reset_imem_req", {31'd0, a.imem_req}, 32'd1);
        check("post_reset_no_retire", {31'd0, a.ret}, 32'd0);
        @(posedge i_clk); #1;
        add_instr(7'b0000011, 0, 0, "load_after_reset", n); check("len_load", n, 5);
        add_instr(7'b1100011, 1, 0, "branch_after_reset", n);
        run_queue();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the memory-wait limit in cycles (used only with MC_TIMEOUT_EN; legal range 1..255).
REQ-002 SHALL have these ports:
- i_clk  in  1  sole clock; all state changes on its rising edge.
- i_rst  in  1  reset; asynchronous, active-high.
- i_OPCode  in  7  instruction opcode from the instruction register.
- i_imem_ready  in  1  instruction memory completes the fetch this cycle.
- i_dmem_ready  in  1  data memory completes the access this cycle.
- o_imem_req  out  1  fetch request.
- o_dmem_req  out  1  data access request.
- o_IRWrite  out  1  load instruction register.
- o_PCWrite  out  1  PC <- PC+4.
- o_Branch  out  1  conditional PC update on branch compare.
- o_MemRead  out  1  data read.
- o_MemWrite  out  1  data write.
- o_MemToReg  out  1  writeback source is memory.
- o_ALUSrc1  out  1  ALU operand A is PC.
- o_ALUSrc2  out  1  ALU operand B is immediate.
- o_ALUOp  out  3  ALU operation class.
- o_RegWrite  out  1  register file write.
- o_retire  out  1  one-cycle pulse on the last cycle of each instruction.
- o_illegal  out  1  one-cycle pulse for an unsupported opcode.
- o_bus_error  out  1  one-cycle pulse on memory timeout.
- o_state  out  3  current state encoding.

Function
REQ-003 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 SHALL go to FETCH on the next edge.
REQ-004 FETCH:
- o_imem_req=1; stay in FETCH while i_imem_ready=0.
- When i_imem_ready=1, the same cycle asserts o_IRWrite=1 and o_PCWrite=1, and the next state is DECODE.
REQ-005 DECODE: single cycle; SHALL latch i_OPCode into an internal opcode register; i_OPCode SHALL be ignored in every other state.
REQ-006 DECODE opcodes:
- Supported: R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, LUI 0110111, AUIPC 0010111 -> EXEC.
- Any other opcode -> o_illegal=1 and o_retire=1 that cycle, next state FETCH.
REQ-007 EXEC o_ALUOp per latched opcode: R=010, I=011, LOAD/STORE=000, BRANCH=001, LUI/AUIPC=100.
REQ-008 EXEC other outputs:
- o_ALUSrc2=1 for I/LOAD/STORE.
- o_ALUSrc1=1 for AUIPC only.
- BRANCH: o_Branch=1 and o_retire=1, next FETCH.
- LOAD/STORE: next MEM.
- All other supported opcodes: next WB.
REQ-009 MEM:
- o_dmem_req=1; o_MemRead=1 for LOAD, o_MemWrite=1 for STORE; o_ALUOp, o_ALUSrc2 held at EXEC values.
- Stay in MEM while i_dmem_ready=0.
- On i_dmem_ready=1: LOAD -> WB; STORE -> FETCH with o_retire=1.
REQ-010 WB: o_RegWrite=1 for exactly one cycle, o_MemToReg=1 only for LOAD, o_retire=1; next FETCH.
REQ-011 Outputs not listed as asserted in a state SHALL be 0; no X on any output in any state.
REQ-012 Latency with zero-wait memory: BRANCH 3, R/I/LUI/AUIPC/STORE 4, LOAD 5 cycles; each wait cycle adds one cycle.
REQ-013 o_retire, o_illegal and o_bus_error SHALL each be high for at most one cycle per instruction.

Reset
REQ-014 While i_rst=1: state=FETCH, latched opcode=0, timeout counter=0, and all outputs 0 (including o_imem_req), regardless of i_clk.
REQ-015 The first cycle after i_rst deassertion SHALL be FETCH with o_imem_req=1; reset asserted mid-instruction SHALL abort it with no o_retire.

Configuration
REQ-016 Macro MC_TIMEOUT_EN defined:
- An 8-bit counter clears on entry to FETCH or MEM and increments each wait cycle.
- When the count reaches TIMEOUT_CYCLES with ready still 0: o_bus_error=1 for one cycle, requests drop, next state FETCH, no o_retire.
- A ready arriving in the same cycle as the limit SHALL win.
REQ-017 Macro MC_TIMEOUT_EN undefined: waits are unbounded, no counter logic, and o_bus_error is tied to 0.

Verification
REQ-018 Reset, then R-type 0110011 with both readies held at 1 -> states 0,1,2,4; o_RegWrite and o_retire high on cycle 4 only; o_ALUOp=010 in EXEC.
REQ-019 LOAD 0000011 with i_dmem_ready low for 3 MEM cycles -> MEM occupies 4 cycles; WB has o_MemToReg=1 and o_RegWrite=1; total 8 cycles.
REQ-020 STORE then BRANCH back-to-back -> STORE retires from MEM with o_MemWrite=1 and o_RegWrite never 1; BRANCH retires from EXEC with o_Branch=1 and o_ALUOp=001.
REQ-021 Opcode 1111111 -> o_illegal=1 and o_retire=1 in DECODE; next state FETCH; no write strobes asserted.
REQ-022 With MC_TIMEOUT_EN and TIMEOUT_CYCLES=4, i_imem_ready held at 0 -> o_bus_error pulses once, FETCH restarts; i_rst raised during MEM -> outputs 0 immediately, FETCH follows release.
